tile_drawer: RTL and testbench

TILE_DRAWER -- requirements
Module: tile_drawer

---
 rtl/tile_drawer_pkg.sv | 61 ++++++
 rtl/tile_drawer_if.sv | 36 +++
 rtl/tile_row_unpack.sv | 24 ++
 rtl/tile_drawer.sv | 222 ++++++++++++++++++++++
 tb/tb_tile_drawer.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/tile_drawer_pkg.sv
// -----------------------------------------------------------------------------
// tile_drawer_pkg
//   Shared display definitions for the background tile renderer:
//   - display / tile-map geometry constants
//   - bus widths used by the renderer interface
//   - TAM entry layout (tam_entry_t)
//   - renderer FSM state encodings and the matching state_e enum
//   - flip_row(): texel-row selection under vertical flip
// -----------------------------------------------------------------------------
package tile_drawer_pkg;

  // Display and tile-map geometry
  localparam int DISPLAY_WIDTH  = 640;  // visible pixels per line
  localparam int DISPLAY_HEIGHT = 480;  // visible lines
  localparam int TILE_PX        = 16;   // tile edge in texels
  localparam int SCALE          = 2;    // screen pixels per texel, each axis
  localparam int MAP_COLS       = 20;   // tile-map columns
  localparam int MAP_ROWS       = 15;   // tile-map rows

  // Bus widths
  localparam int LINE_W   = 10;
  localparam int TAM_AW   = 10;
  localparam int TAM_DW   = 16;
  localparam int VRAM_AW  = 12;
  localparam int TEXEL_W  = 8;
  localparam int VRAM_DW  = TILE_PX * TEXEL_W;

  // Tile attribute memory entry
  typedef struct packed {
    logic [5:0] rsvd;      // ignored
    logic       vflip;
    logic       hflip;
    logic [7:0] tile_idx;
  } tam_entry_t;

  // FSM state encodings (plain constants so the state register stays a
  // simple vector), plus an enum view with the same values.
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_TAM_REQ   = 3'd1;
  localparam logic [2:0] ST_TAM_WAIT  = 3'd2;
  localparam logic [2:0] ST_VRAM_REQ  = 3'd3;
  localparam logic [2:0] ST_VRAM_WAIT = 3'd4;
  localparam logic [2:0] ST_WRITE     = 3'd5;
  localparam logic [2:0] ST_DONE      = 3'd6;

  typedef enum logic [2:0] {
    IDLE      = ST_IDLE,
    TAM_REQ   = ST_TAM_REQ,
    TAM_WAIT  = ST_TAM_WAIT,
    VRAM_REQ  = ST_VRAM_REQ,
    VRAM_WAIT = ST_VRAM_WAIT,
    WRITE     = ST_WRITE,
    DONE      = ST_DONE
  } state_e;

  // Texel row actually fetched: mirrored top-to-bottom when vflip is set.
  function automatic logic [3:0] flip_row(input logic [3:0] t, input logic vflip);
    return vflip ? (4'd15 - t) : t;
  endfunction

endpackage

// File: rtl/tile_drawer_if.sv
// -----------------------------------------------------------------------------
// tile_drawer_if
//   Request/status handshake and memory buses of the tile renderer.
//   master : line requester + memory model side (drives start, line_number,
//            tam_d, vram_d)
//   slave  : renderer side (drives busy, done, tam_a, vram_a)
//   Signals:
//     start        one-cycle render request
//     line_number  screen line to render
//     busy / done  render in progress / one-cycle completion pulse
//     tam_a/tam_d  tile attribute memory address / data (1-cycle latency)
//     vram_a/vram_d tile VRAM row address / 16-texel row (1-cycle latency)
// -----------------------------------------------------------------------------
interface tile_drawer_if;
  import tile_drawer_pkg::*;

  logic                start;
  logic [LINE_W-1:0]   line_number;
  logic                busy;
  logic                done;
  logic [TAM_AW-1:0]   tam_a;
  logic [TAM_DW-1:0]   tam_d;
  logic [VRAM_AW-1:0]  vram_a;
  logic [VRAM_DW-1:0]  vram_d;

  modport master (
    output start, line_number, tam_d, vram_d,
    input  busy, done, tam_a, vram_a
  );

  modport slave (
    input  start, line_number, tam_d, vram_d,
    output busy, done, tam_a, vram_a
  );

endinterface

// File: rtl/tile_row_unpack.sv
// -----------------------------------------------------------------------------
// tile_row_unpack
//   Combinational split of one VRAM texel row into individual texels.
//   Ports:
//     row_i    packed row, texel 0 in the least significant byte
//     hflip_i  mirror the row left-to-right
//     texel_o  texel_o[p] = texel p, or texel N-1-p when hflip_i is set
// -----------------------------------------------------------------------------
module tile_row_unpack
  import tile_drawer_pkg::*;
#(
  parameter int N_TEXELS = TILE_PX
) (
  input  logic [N_TEXELS*TEXEL_W-1:0] row_i,
  input  logic                        hflip_i,
  output logic [TEXEL_W-1:0]          texel_o [N_TEXELS]
);

  for (genvar gi = 0; gi < N_TEXELS; gi++) begin : g_texel
    assign texel_o[gi] = hflip_i ? row_i[(N_TEXELS-1-gi)*TEXEL_W +: TEXEL_W]
                                 : row_i[gi*TEXEL_W +: TEXEL_W];
  end

endmodule

// File: rtl/tile_drawer.sv
// -----------------------------------------------------------------------------
// tile_drawer
//   Renders one background scan line from a tile map into line_buffer.
//   For each of the map columns on the requested line it reads the tile
//   attribute (TAM), then the matching texel row (VRAM), and writes every
//   texel twice (horizontal scaling) into the line buffer. Each column takes
//   five cycles: TAM_REQ, TAM_WAIT, VRAM_REQ, VRAM_WAIT, WRITE.
//   Ports:
//     clk          pixel clock
//     rst          asynchronous active-high reset
//     bus          renderer side of tile_drawer_if (start/line_number in,
//                  busy/done out, TAM and VRAM read buses)
//     line_buffer  background colour indices of the last rendered line
// -----------------------------------------------------------------------------
module tile_drawer
  import tile_drawer_pkg::tam_entry_t, tile_drawer_pkg::flip_row,
         tile_drawer_pkg::ST_IDLE, tile_drawer_pkg::ST_TAM_REQ,
         tile_drawer_pkg::ST_TAM_WAIT, tile_drawer_pkg::ST_VRAM_REQ,
         tile_drawer_pkg::ST_VRAM_WAIT, tile_drawer_pkg::ST_WRITE,
         tile_drawer_pkg::ST_DONE;
#(
  parameter int DISPLAY_WIDTH  = tile_drawer_pkg::DISPLAY_WIDTH,
  parameter int DISPLAY_HEIGHT = tile_drawer_pkg::DISPLAY_HEIGHT,
  parameter int TILE_PX        = tile_drawer_pkg::TILE_PX,
  parameter int SCALE          = tile_drawer_pkg::SCALE,
  parameter int MAP_COLS       = tile_drawer_pkg::MAP_COLS,
  parameter int MAP_ROWS       = tile_drawer_pkg::MAP_ROWS
) (
  input  logic                                clk,
  input  logic                                rst,
  tile_drawer_if.slave                        bus,
  output logic [tile_drawer_pkg::TEXEL_W-1:0] line_buffer [DISPLAY_WIDTH]
);

  localparam int TEXEL_W   = tile_drawer_pkg::TEXEL_W;
  localparam int VRAM_DW   = tile_drawer_pkg::VRAM_DW;
  localparam int TILE_SPAN = TILE_PX * SCALE;        // screen pixels per tile edge
  localparam int COL_W     = $clog2(MAP_COLS);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [2:0]         state_q,  state_d;
  logic [9:0]         line_q,   line_d;     // line latched at accepted start
  logic [9:0]         base_q,   base_d;     // map row * MAP_COLS
  logic [COL_W-1:0]   col_q,    col_d;      // current map column
  logic               oor_q,    oor_d;      // latched line is off-screen
  logic [9:0]         tam_a_q,  tam_a_d;
  logic [11:0]        vram_a_q, vram_a_d;
  logic               hflip_q,  hflip_d;    // hflip of the tile being drawn
  logic [VRAM_DW-1:0] row_q,    row_d;      // fetched texel row

  logic               lb_write;
  logic               lb_clear;

  // ---------------------------------------------------------------------------
  // Address arithmetic
  // ---------------------------------------------------------------------------
  logic [9:0]  in_row;       // map row of the incoming line_number
  logic [9:0]  in_base;
  logic        in_oor;
  logic [9:0]  half_line;
  logic [3:0]  tex_row;      // texel row before vflip
  tam_entry_t  tam_entry;
  logic        unused_rsvd;

  assign in_row    = bus.line_number / 10'(TILE_SPAN);
  assign in_base   = in_row * 10'(MAP_COLS);
  assign in_oor    = (bus.line_number >= 10'(DISPLAY_HEIGHT)) ||
                     (in_row >= 10'(MAP_ROWS));

  assign half_line = line_q / 10'(SCALE);
  assign tex_row   = 4'(half_line % 10'(TILE_PX));

  assign tam_entry   = tam_entry_t'(bus.tam_d);
  assign unused_rsvd = ^tam_entry.rsvd;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    line_d   = line_q;
    base_d   = base_q;
    col_d    = col_q;
    oor_d    = oor_q;
    tam_a_d  = tam_a_q;
    vram_a_d = vram_a_q;
    hflip_d  = hflip_q;
    row_d    = row_q;
    lb_write = 1'b0;
    lb_clear = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_TAM_REQ;
          line_d  = bus.line_number;
          base_d  = in_base;
          col_d   = '0;
          oor_d   = in_oor;
          // Address is set on entry so it is stable during TAM_REQ; an
          // off-screen line leaves both memory addresses untouched.
          if (!in_oor) begin
            tam_a_d = in_base;
          end
        end
      end

      ST_TAM_REQ: begin
        if (oor_q) begin
          lb_clear = 1'b1;
          state_d  = ST_DONE;
        end else begin
          state_d  = ST_TAM_WAIT;
        end
      end

      ST_TAM_WAIT: begin
        // TAM data is valid now; form the VRAM row address directly from it.
        hflip_d  = tam_entry.hflip;
        vram_a_d = {tam_entry.tile_idx, flip_row(tex_row, tam_entry.vflip)};
        state_d  = ST_VRAM_REQ;
      end

      ST_VRAM_REQ: begin
        state_d = ST_VRAM_WAIT;
      end

      ST_VRAM_WAIT: begin
        row_d   = bus.vram_d;
        state_d = ST_WRITE;
      end

      ST_WRITE: begin
        lb_write = 1'b1;
        if (col_q == COL_W'(MAP_COLS - 1)) begin
          state_d = ST_DONE;
        end else begin
          col_d   = col_q + 1'b1;
          tam_a_d = base_q + 10'(col_q) + 10'd1;
          state_d = ST_TAM_REQ;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      line_q   <= '0;
      base_q   <= '0;
      col_q    <= '0;
      oor_q    <= 1'b0;
      tam_a_q  <= '0;
      vram_a_q <= '0;
      hflip_q  <= 1'b0;
      row_q    <= '0;
    end else begin
      state_q  <= state_d;
      line_q   <= line_d;
      base_q   <= base_d;
      col_q    <= col_d;
      oor_q    <= oor_d;
      tam_a_q  <= tam_a_d;
      vram_a_q <= vram_a_d;
      hflip_q  <= hflip_d;
      row_q    <= row_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Texel unpack and line buffer
  // ---------------------------------------------------------------------------
  logic [TEXEL_W-1:0] texel [TILE_PX];

  tile_row_unpack #(
    .N_TEXELS (TILE_PX)
  ) u_unpack (
    .row_i   (row_q),
    .hflip_i (hflip_q),
    .texel_o (texel)
  );

  // Each screen pixel belongs to one map column; it takes texel
  // (pixel offset within the tile) / SCALE when that column is written.
  for (genvar gi = 0; gi < DISPLAY_WIDTH; gi++) begin : g_lb
    logic [TEXEL_W-1:0] px_q;
    logic               col_hit;

    assign col_hit = (col_q == COL_W'(gi / TILE_SPAN));

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        px_q <= '0;
      end else if (lb_clear) begin
        px_q <= '0;
      end else if (lb_write && col_hit) begin
        px_q <= texel[(gi % TILE_SPAN) / SCALE];
      end
    end

    assign line_buffer[gi] = px_q;
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.busy   = (state_q != ST_IDLE);
  assign bus.done   = (state_q == ST_DONE);
  assign bus.tam_a  = tam_a_q;
  assign bus.vram_a = vram_a_q;

endmodule

// File: tb/tb_tile_drawer.sv
// -----------------------------------------------------------------------------
// tb_tile_drawer
//   Drives line render requests into tile_drawer, models the TAM and VRAM
//   (1-cycle registered reads) and compares the rendered line, addresses and
//   timing against a per-pixel reference computed from the tile-map rules.
// -----------------------------------------------------------------------------
module tb_tile_drawer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tile_drawer_if bus ();
  logic [7:0] lbuf [640];

  tile_drawer dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .line_buffer (lbuf)
  );

  // Memories with one-cycle registered read
  logic [15:0]  tam_mem  [1024];
  logic [127:0] vram_mem [4096];

  always @(posedge clk) begin
    bus.tam_d  <= tam_mem[bus.tam_a];
    bus.vram_d <= vram_mem[bus.vram_a];
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: colour of screen pixel x on line L
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] ref_px(input int L, input int x);
    logic [15:0]  e;
    logic [127:0] row;
    int t;
    int p;
    e = tam_mem[(L / 32) * 20 + x / 32];
    t = (L / 2) % 16;
    if (e[9]) t = 15 - t;
    row = vram_mem[int'(e[7:0]) * 16 + t];
    p = (x % 32) / 2;
    if (e[8]) p = 15 - p;
    return row[p*8 +: 8];
  endfunction

  function automatic int ref_vram_a(input int L, input int c);
    logic [15:0] e;
    int t;
    e = tam_mem[(L / 32) * 20 + c];
    t = (L / 2) % 16;
    if (e[9]) t = 15 - t;
    return int'(e[7:0]) * 16 + t;
  endfunction

  task automatic fill_mem();
    for (int i = 0; i < 1024; i++) tam_mem[i] = 16'($urandom);
    for (int i = 0; i < 4096; i++) begin
      vram_mem[i] = {$urandom, $urandom, $urandom, $urandom};
      vram_mem[i][(i % 16)*8 +: 8] = 8'h00;   // transparent texels too
    end
  endtask

  // ---------------------------------------------------------------------------
  // One render, observed cycle by cycle (cycle 0 = start accepted)
  // ---------------------------------------------------------------------------
  int lat, ndone, busy_bad, tam_bad, vram_bad, addr_moved;
  int tam_first, tam_last, vram_first;

  task automatic run_line(input int L, input bit pulse_busy);
    int exp_lat;
    int stop;
    int c;
    logic [9:0]  pre_t;
    logic [11:0] pre_v;
    exp_lat = (L >= 480) ? 2 : 101;
    stop = pulse_busy ? 260 : exp_lat + 3;
    lat = -1; ndone = 0; busy_bad = 0; tam_bad = 0; vram_bad = 0; addr_moved = 0;
    tam_first = -1; tam_last = -1; vram_first = -1;
    @(posedge clk); #1;
    pre_t = bus.tam_a;
    pre_v = bus.vram_a;
    bus.start = 1'b1;
    bus.line_number = 10'(L);
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.line_number = 10'($urandom_range(0, 1023));   // must not disturb the render
    for (int cyc = 1; cyc <= stop; cyc++) begin
      if (bus.done === 1'b1) begin
        ndone++;
        if (lat < 0) lat = cyc;
      end
      if (bus.busy !== (cyc <= exp_lat)) busy_bad++;
      if (L < 480 && cyc <= 100) begin
        c = (cyc - 1) / 5;
        if ((cyc - 1) % 5 == 0) begin
          if (c == 0)  tam_first = int'(bus.tam_a);
          if (c == 19) tam_last  = int'(bus.tam_a);
          if (bus.tam_a !== 10'((L / 32) * 20 + c)) tam_bad++;
        end
        if ((cyc - 1) % 5 == 2) begin
          if (c == 0) vram_first = int'(bus.vram_a);
          if (bus.vram_a !== 12'(ref_vram_a(L, c))) vram_bad++;
        end
      end
      if (L >= 480 && (bus.tam_a !== pre_t || bus.vram_a !== pre_v)) addr_moved++;
      bus.start = pulse_busy && (cyc == 10 || cyc == 50);
      if (bus.start) bus.line_number = 10'($urandom_range(0, 479));
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
  endtask

  task automatic check_line(input int L);
    int bad;
    logic [7:0] e;
    chk($sformatf("L%0d latency", L), 64'(lat), 64'((L >= 480) ? 2 : 101));
    chk($sformatf("L%0d done_pulses", L), 64'(ndone), 64'd1);
    chk($sformatf("L%0d busy_errs", L), 64'(busy_bad), 64'd0);
    bad = 0;
    for (int x = 0; x < 640; x++) begin
      e = (L >= 480) ? 8'h00 : ref_px(L, x);
      if (lbuf[x] !== e) bad++;
    end
    chk($sformatf("L%0d line_buffer_errs", L), 64'(bad), 64'd0);
    if (L < 480) begin
      chk($sformatf("L%0d tam_a_errs", L), 64'(tam_bad), 64'd0);
      chk($sformatf("L%0d vram_a_errs", L), 64'(vram_bad), 64'd0);
    end else begin
      chk($sformatf("L%0d addr_moved", L), 64'(addr_moved), 64'd0);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    int bad;
    int nd;
    int L;
    int idx;
    logic [127:0] r;

    bus.start = 1'b0;
    bus.line_number = '0;
    fill_mem();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    // Reset state
    chk("rst busy", 64'(bus.busy), 64'd0);
    chk("rst done", 64'(bus.done), 64'd0);
    chk("rst tam_a", 64'(bus.tam_a), 64'd0);
    chk("rst vram_a", 64'(bus.vram_a), 64'd0);
    bad = 0;
    for (int x = 0; x < 640; x++) if (lbuf[x] !== 8'h00) bad++;
    chk("rst line_buffer_nonzero", 64'(bad), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Line 0, tile 3, texels 0x10..0x1F
    tam_mem[0] = 16'h0003;
    for (int i = 0; i < 16; i++) vram_mem[48][i*8 +: 8] = 8'(8'h10 + i);
    run_line(0, 1'b0);
    check_line(0);
    bad = 0;
    for (int i = 0; i < 32; i++) if (lbuf[i] !== 8'(8'h10 + i / 2)) bad++;
    chk("line0 first_tile_errs", 64'(bad), 64'd0);

    // Both flips on line 5
    idx = $urandom_range(0, 255);
    tam_mem[0] = {6'h2a, 1'b1, 1'b1, 8'(idx)};
    run_line(5, 1'b0);
    check_line(5);
    chk("flip vram_a", 64'(vram_first), 64'(idx * 16 + (15 - (5 / 2) % 16)));
    r = vram_mem[idx * 16 + (15 - (5 / 2) % 16)];
    chk("flip lb0", 64'(lbuf[0]), 64'(r[127:120]));
    chk("flip lb31", 64'(lbuf[31]), 64'(r[7:0]));

    // Last tile on the last visible line
    tam_mem[299][9] = 1'b0;
    run_line(479, 1'b0);
    check_line(479);
    chk("last tam_first", 64'(tam_first), 64'd280);
    chk("last tam_last", 64'(tam_last), 64'd299);
    r = vram_mem[int'(tam_mem[299][7:0]) * 16 + 15];
    bad = 0;
    for (int x = 608; x < 640; x++) begin
      idx = (x - 608) / 2;
      if (tam_mem[299][8]) idx = 15 - idx;
      if (lbuf[x] !== r[idx*8 +: 8]) bad++;
    end
    chk("last tile_errs", 64'(bad), 64'd0);

    // Off-screen line
    run_line(500, 1'b0);
    check_line(500);

    // Start pulses while busy are ignored
    L = $urandom_range(0, 479);
    run_line(L, 1'b1);
    check_line(L);

    // Reset in the middle of a render
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.line_number = 10'($urandom_range(0, 479));
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (39) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst busy", 64'(bus.busy), 64'd0);
    chk("midrst done", 64'(bus.done), 64'd0);
    bad = 0;
    for (int x = 0; x < 640; x++) if (lbuf[x] !== 8'h00) bad++;
    chk("midrst line_buffer_nonzero", 64'(bad), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    nd = 0;
    repeat (120) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) nd++;
    end
    chk("midrst stray_done", 64'(nd), 64'd0);
    L = $urandom_range(0, 479);
    run_line(L, 1'b0);
    check_line(L);

    // Random lines on fresh memory contents, including row boundaries
    fill_mem();
    for (int k = 0; k < 6; k++) begin
      case (k)
        0: L = 31;
        1: L = 32;
        2: L = 478;
        3: L = $urandom_range(480, 1023);
        default: L = $urandom_range(0, 479);
      endcase
      run_line(L, 1'b0);
      check_line(L);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
